// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master behind a 4-register bus slave; one-cycle write/read acks, each held CE yields one access.
// Transfer: CLK_DIV setup + DATA_W SCLK periods + CLK_DIV hold; START/TXDATA writes during a transfer set OVR.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic [31:0]  bus2ip_data,
  input  logic [3:0]   bus2ip_wrce,
  input  logic [3:0]   bus2ip_rdce,
  output logic [127:0] ip2bus_data,
  output logic         ip2bus_wrack,
  output logic         ip2bus_rdack,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO,
  output logic [3:0]   SS_n
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic                phase_q, phase_d;
  logic                samp_q, samp_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [3:0]          ssel_q, ssel_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                wrack_q, wrack_d;
  logic                rdack_q, rdack_d;
  logic                wr_hold_q, wr_hold_d;
  logic                rd_hold_q, rd_hold_d;
  logic [1:0]          rd_idx_q, rd_idx_d;

  logic                busy, wr_commit, rd_commit, start_go, set_ovr, set_done, clr_flags;
  logic [1:0]          wr_idx;
  logic                unused_bits;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign unused_bits = ^bus2ip_data;
  assign busy        = (state_q != IDLE);
  assign wr_idx      = low_idx(bus2ip_wrce);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    samp_d    = samp_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ssel_d    = ssel_q;
    start_go  = 1'b0;
    set_ovr   = 1'b0;
    set_done  = 1'b0;
    clr_flags = 1'b0;

    // The hold flag blocks re-commits while the bridge keeps CE asserted after the ack.
    wr_commit = (|bus2ip_wrce) && !wrack_q && !wr_hold_q;
    rd_commit = (|bus2ip_rdce) && !rdack_q && !rd_hold_q;
    wrack_d   = wr_commit;
    rdack_d   = rd_commit;
    wr_hold_d = (wr_hold_q | wr_commit) & (|bus2ip_wrce);
    rd_hold_d = (rd_hold_q | rd_commit) & (|bus2ip_rdce);
    rd_idx_d  = rd_commit ? low_idx(bus2ip_rdce) : rd_idx_q;

    if (rdack_q && rd_idx_q == 2'd3) clr_flags = 1'b1;

    if (wr_commit) begin
      case (wr_idx)
        2'd0: begin
          if (busy) begin
            set_ovr = bus2ip_data[0];
          end else begin
            ssel_d   = bus2ip_data[7:4];
            start_go = bus2ip_data[0];
          end
        end
        2'd2: begin
          if (busy) set_ovr = 1'b1;
          else      tx_d    = bus2ip_data[DATA_W-1:0];
        end
        default: ;
      endcase
    end

    if (start_go) begin
      clr_flags = 1'b1;
      state_d   = SETUP;
      cnt_d     = 8'd0;
      shreg_d   = tx_q;
    end

    case (state_q)
      SETUP: begin
        if (cnt_q == DIV_M1) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          phase_d = 1'b0;
          bit_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
            samp_d  = MISO;
          end else begin
            // Falling edge: shift the captured bit in and expose the next MOSI bit.
            phase_d = 1'b0;
            shreg_d = (shreg_q << 1) | DATA_W'(samp_q);
            if (bit_q == LAST_BIT) state_d = HOLD;
            else                   bit_d   = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == DIV_M1) begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          rx_d     = shreg_q;
          set_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    done_d = set_done | (done_q & ~clr_flags);
    ovr_d  = set_ovr  | (ovr_q  & ~clr_flags);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      samp_q    <= 1'b0;
      shreg_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      ssel_q    <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wrack_q   <= 1'b0;
      rdack_q   <= 1'b0;
      wr_hold_q <= 1'b0;
      rd_hold_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      samp_q    <= samp_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ssel_q    <= ssel_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      wrack_q   <= wrack_d;
      rdack_q   <= rdack_d;
      wr_hold_q <= wr_hold_d;
      rd_hold_q <= rd_hold_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  assign ip2bus_wrack = wrack_q;
  assign ip2bus_rdack = rdack_q;
  assign SCLK         = (state_q == SHIFT) && phase_q;
  assign MOSI         = ((state_q == SETUP) || (state_q == SHIFT)) ? shreg_q[DATA_W-1] : 1'b0;
  assign SS_n         = busy ? ~ssel_q : 4'hF;

  assign ip2bus_data[31:0]   = {24'd0, ssel_q, 4'd0};
  assign ip2bus_data[63:32]  = {29'd0, ovr_q, done_q, busy};
  assign ip2bus_data[95:64]  = 32'(tx_q);
  assign ip2bus_data[127:96] = 32'(rx_q);

endmodule
